// File: rtl/pattern_sequencer.sv
// Frame-aligned pattern select sequencer for the VGA test pattern generator (optional blanking: PATTERN_SEQ_BLANK_EN).
// Latency: o_pattern/o_changed update one cycle after the committing i_frame_strobe.
// Backpressure: none; requests are held in a single latest-wins slot until the next frame strobe.
module pattern_sequencer #(
    parameter int NUM_PATTERNS       = 10,
    parameter int FIRST_PATTERN      = 1,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BLANK_FRAMES       = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_strobe,
    input  logic       i_next,
    input  logic       i_prev,
    input  logic       i_auto,
    output logic [3:0] o_pattern,
    output logic       o_changed,
    output logic       o_busy
);

    localparam int              CW       = $clog2(FRAMES_PER_PATTERN) + 1;
    localparam logic [3:0]      P_FIRST  = 4'(FIRST_PATTERN);
    localparam logic [3:0]      P_LAST   = 4'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FRAMES_PER_PATTERN - 1);

    // Reject parameter sets outside the legal ranges at elaboration.
    if ((NUM_PATTERNS < 2) || (NUM_PATTERNS > 16) || (FIRST_PATTERN < 0) ||
        (FIRST_PATTERN >= NUM_PATTERNS - 1) || (FRAMES_PER_PATTERN < 1) ||
        (BLANK_FRAMES < 1)) begin : g_bad_params
        $error("pattern_sequencer: illegal parameter combination");
    end

`ifdef PATTERN_SEQ_BLANK_EN
    localparam int            BW         = $clog2(BLANK_FRAMES) + 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_PENDING = 2'd1, S_BLANK = 2'd2} state_t;
    logic [3:0]    r_target,    w_target_nxt;
    logic [BW-1:0] r_blank_cnt, w_blank_cnt_nxt;
`else
    typedef enum logic [1:0] {S_RUN = 2'd0, S_PENDING = 2'd1} state_t;
`endif

    state_t        r_state,    w_state_nxt;
    logic          r_pend_vld, w_pend_vld_nxt;
    logic          r_pend_dir, w_pend_dir_nxt;   // 1 = next, 0 = prev
    logic [3:0]    r_pattern,  w_pattern_nxt;
    logic          r_changed,  w_changed_nxt;
    logic [CW-1:0] r_auto_cnt, w_auto_cnt_nxt;

    logic       w_req_vld, w_eff_vld, w_eff_dir, w_in_run, w_auto_hit, w_commit;
    logic [3:0] w_target;

    // One step through FIRST..LAST with wrap at both ends.
    function automatic logic [3:0] f_step(input logic [3:0] pat, input logic dir);
        if (dir) f_step = (pat == P_LAST)  ? P_FIRST : pat + 4'd1;
        else     f_step = (pat == P_FIRST) ? P_LAST  : pat - 4'd1;
    endfunction

    // A fresh single-direction request overrides whatever is already latched.
    assign w_req_vld  = i_next ^ i_prev;
    assign w_eff_vld  = w_req_vld | r_pend_vld;
    assign w_eff_dir  = w_req_vld ? i_next : r_pend_dir;
    assign w_in_run   = (r_state == S_RUN);
    assign w_auto_hit = w_in_run && i_auto && (r_auto_cnt == CNT_LAST);
    assign w_commit   = ((r_state == S_RUN) || (r_state == S_PENDING)) && i_frame_strobe &&
                        (w_eff_vld || w_auto_hit);
    // Manual requests win over the auto step.
    assign w_target   = f_step(r_pattern, w_eff_vld ? w_eff_dir : 1'b1);

    // Next-state, request latch, auto dwell counter and output selection.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_dir_nxt = r_pend_dir;
        w_pattern_nxt  = r_pattern;
        w_changed_nxt  = 1'b0;
`ifdef PATTERN_SEQ_BLANK_EN
        w_target_nxt    = r_target;
        w_blank_cnt_nxt = r_blank_cnt;
`endif
        if (w_req_vld) begin
            w_pend_vld_nxt = 1'b1;
            w_pend_dir_nxt = i_next;
        end

        if (!w_in_run || !i_auto || w_commit) w_auto_cnt_nxt = '0;
        else if (i_frame_strobe)             w_auto_cnt_nxt = r_auto_cnt + CW'(1);
        else                                 w_auto_cnt_nxt = r_auto_cnt;

        case (r_state)
            S_RUN, S_PENDING: begin
                if (w_commit) begin
                    w_pend_vld_nxt = 1'b0;
`ifdef PATTERN_SEQ_BLANK_EN
                    w_pattern_nxt   = 4'd0;
                    w_target_nxt    = w_target;
                    w_blank_cnt_nxt = '0;
                    w_state_nxt     = S_BLANK;
`else
                    w_pattern_nxt   = w_target;
                    w_changed_nxt   = 1'b1;
                    w_state_nxt     = S_RUN;
`endif
                end else if (w_eff_vld) begin
                    w_state_nxt = S_PENDING;
                end
            end
`ifdef PATTERN_SEQ_BLANK_EN
            S_BLANK: begin
                if (i_frame_strobe) begin
                    if (r_blank_cnt == BLANK_LAST) begin
                        w_pattern_nxt = r_target;
                        w_changed_nxt = 1'b1;
                        // Anything latched during blanking waits for the next strobe.
                        w_state_nxt   = w_pend_vld_nxt ? S_PENDING : S_RUN;
                    end else begin
                        w_blank_cnt_nxt = r_blank_cnt + BW'(1);
                    end
                end
            end
`endif
            default: w_state_nxt = S_RUN;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_RUN;
            r_pend_vld <= 1'b0;
            r_pend_dir <= 1'b0;
            r_pattern  <= P_FIRST;
            r_changed  <= 1'b0;
            r_auto_cnt <= '0;
`ifdef PATTERN_SEQ_BLANK_EN
            r_target    <= P_FIRST;
            r_blank_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_dir <= w_pend_dir_nxt;
            r_pattern  <= w_pattern_nxt;
            r_changed  <= w_changed_nxt;
            r_auto_cnt <= w_auto_cnt_nxt;
`ifdef PATTERN_SEQ_BLANK_EN
            r_target    <= w_target_nxt;
            r_blank_cnt <= w_blank_cnt_nxt;
`endif
        end
    end

    assign o_pattern = r_pattern;
    assign o_changed = r_changed;
    assign o_busy    = (r_state != S_RUN);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed vectors plus a frame-level reference model compared every cycle.
// Latency: model outputs are valid from the clock edge that commits them.
// Backpressure: not applicable.
module tb_pattern_sequencer;

    localparam int NP    = 10;
    localparam int FIRST = 1;
    localparam int FPP   = 3;
    localparam int BF    = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_strobe = 1'b0, i_next = 1'b0, i_prev = 1'b0, i_auto = 1'b0;
    logic [3:0] o_pattern;
    logic       o_changed, o_busy;

    int n_checks = 0;
    int n_err    = 0;

    pattern_sequencer #(
        .NUM_PATTERNS(NP), .FIRST_PATTERN(FIRST),
        .FRAMES_PER_PATTERN(FPP), .BLANK_FRAMES(BF)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_strobe(i_strobe),
        .i_next(i_next), .i_prev(i_prev), .i_auto(i_auto),
        .o_pattern(o_pattern), .o_changed(o_changed), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame-level view) ----------------
    int m_pat, m_chg, m_busy, m_pend, m_dwell, m_blank, m_tgt;
    int m_req, m_eff;

    function automatic int stepf(input int p, input int d);
        int r;
        r = NP - FIRST;
        return ((p - FIRST + d + r) % r) + FIRST;
    endfunction

    task automatic m_commit(input int d);
        m_tgt  = stepf(m_pat, d);
        m_pend = 0;
`ifdef PATTERN_SEQ_BLANK_EN
        m_pat   = 0;
        m_blank = BF;
`else
        m_pat = m_tgt;
        m_chg = 1;
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pat = FIRST; m_chg = 0; m_busy = 0; m_pend = 0;
            m_dwell = 0; m_blank = 0; m_tgt = FIRST;
        end else begin
            m_req = (i_next != i_prev) ? (i_next ? 1 : -1) : 0;
            m_chg = 0;
            if (m_blank > 0) begin
                if (m_req != 0) m_pend = m_req;
                if (i_strobe) begin
                    m_blank = m_blank - 1;
                    if (m_blank == 0) begin
                        m_pat = m_tgt;
                        m_chg = 1;
                    end
                end
                m_dwell = 0;
            end else begin
                m_eff = (m_req != 0) ? m_req : m_pend;
                if (i_strobe && m_eff != 0) begin
                    m_commit(m_eff);
                    m_dwell = 0;
                end else if (i_strobe && i_auto) begin
                    if (m_dwell == FPP - 1) begin
                        m_commit(1);
                        m_dwell = 0;
                    end else begin
                        m_dwell = m_dwell + 1;
                    end
                end else begin
                    m_pend = m_eff;
                end
                if (!i_auto || m_pend != 0) m_dwell = 0;
            end
            m_busy = (m_blank > 0 || m_pend != 0) ? 1 : 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        n_checks++;
        if (int'(o_pattern) != m_pat || int'(o_changed) != m_chg || int'(o_busy) != m_busy) begin
            n_err++;
            $display("FAIL model t=%0t pattern=%0d/%0d changed=%0d/%0d busy=%0d/%0d (actual/required)",
                     $time, o_pattern, m_pat, o_changed, m_chg, o_busy, m_busy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic n, input logic p, input logic s);
        @(negedge clk);
        #1;
        i_next = n; i_prev = p; i_strobe = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Strobe with an optional request, then finish any blanking so the
    // caller observes the cycle in which o_changed for the target is high.
    task automatic strobe_req(input logic n, input logic p);
        drive(n, p, 1'b1);
`ifdef PATTERN_SEQ_BLANK_EN
        repeat (BF) drive(1'b0, 1'b0, 1'b1);
`endif
        idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_pattern", o_pattern, 1);
        check("reset_changed", o_changed, 0);
        check("reset_busy",    o_busy,    0);
        rst_n = 1'b1;
        idle();

        // First step 1 -> 2 via a latched request.
        drive(1'b1, 1'b0, 1'b0);
        idle();
        check("pending_busy", o_busy, 1);
        check("pending_hold", o_pattern, 1);
        strobe_req(1'b0, 1'b0);
        check("first_step", o_pattern, 2);
        check("first_changed", o_changed, 1);
        idle();
        check("changed_one_cycle", o_changed, 0);
        check("busy_cleared", o_busy, 0);

        // Walk to 9, then wrap forward and back.
        repeat (7) strobe_req(1'b1, 1'b0);
        check("walk_to_9", o_pattern, 9);
        strobe_req(1'b1, 1'b0);
        check("wrap_next", o_pattern, 1);
        strobe_req(1'b0, 1'b1);
        check("wrap_prev", o_pattern, 9);

        // Simultaneous next+prev is ignored.
        drive(1'b1, 1'b1, 1'b0);
        idle();
        check("simul_busy", o_busy, 0);
        drive(1'b0, 1'b0, 1'b1);
        idle();
        check("simul_pattern", o_pattern, 9);
        check("simul_changed", o_changed, 0);

        // prev then next before the strobe: latest wins (9 -> 1).
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        strobe_req(1'b0, 1'b0);
        check("overwrite", o_pattern, 1);
        // Simultaneous pair while pending keeps the pending next.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        strobe_req(1'b0, 1'b0);
        check("pending_kept", o_pattern, 2);

        // Auto mode: advance on every third strobe.
        i_auto = 1'b1;
        repeat (2) begin
            drive(1'b0, 1'b0, 1'b1);
            idle();
        end
        check("auto_dwell", o_pattern, 2);
        strobe_req(1'b0, 1'b0);
        check("auto_step", o_pattern, 3);
        check("auto_changed", o_changed, 1);
        // Manual next on frame 2 steps immediately and restarts the count.
        drive(1'b0, 1'b0, 1'b1);
        idle();
        strobe_req(1'b1, 1'b0);
        check("auto_manual", o_pattern, 4);
        repeat (2) begin
            drive(1'b0, 1'b0, 1'b1);
            idle();
        end
        check("auto_restart", o_pattern, 4);
        strobe_req(1'b0, 1'b0);
        check("auto_after_restart", o_pattern, 5);
        i_auto = 1'b0;
        idle();

`ifdef PATTERN_SEQ_BLANK_EN
        drive(1'b1, 1'b0, 1'b1);
        idle();
        check("blank1_pattern", o_pattern, 0);
        check("blank1_busy", o_busy, 1);
        check("blank1_changed", o_changed, 0);
        drive(1'b0, 1'b0, 1'b1);
        idle();
        check("blank2_pattern", o_pattern, 0);
        check("blank2_changed", o_changed, 0);
        drive(1'b0, 1'b0, 1'b1);
        idle();
        check("blank_target", o_pattern, 6);
        check("blank_target_changed", o_changed, 1);
        check("blank_exit_busy", o_busy, 0);
        // Reset in the middle of blanking.
        drive(1'b1, 1'b0, 1'b1);
        idle();
`else
        // Reset while a request is pending.
        drive(1'b1, 1'b0, 1'b0);
        idle();
`endif
        check("pre_reset_busy", o_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_pattern", o_pattern, 1);
        check("midreset_busy", o_busy, 0);
        check("midreset_changed", o_changed, 0);
        idle();
        idle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        idle();
        check("post_reset_pattern", o_pattern, 1);
        check("post_reset_changed", o_changed, 0);

        // Mixed traffic checked by the model.
        for (int i = 0; i < 800; i++) begin
            if (i % 60 == 0) i_auto = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Frame-aligned controller that drives the 4-bit pattern select of the VGA test pattern generator. It takes single-cycle next/prev requests (debounced button pulses) and an auto-cycle enable, and steps through patterns FIRST_PATTERN..NUM_PATTERNS-1 with wrap-around. Pattern changes commit only on the frame strobe, so a displayed frame never mixes two patterns. It sits between the button/debounce logic and the generator's pattern-select input.

## Interface

**Parameters**
- NUM_PATTERNS, default 10: number of pattern indexes. The valid range is 2..16.
- FIRST_PATTERN, default 1: lowest pattern in the sequence. Pattern 0 (off) is skipped when this is 1.
- FRAMES_PER_PATTERN, default 120: auto-mode dwell, in frames. Must be ≥ 1.
- BLANK_FRAMES, default 2: blank frames inserted per switch. Used only with PATTERN_SEQ_BLANK_EN. Must be ≥ 1.

**Ports**
- i_clk, input, 1: pixel clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_frame_strobe, input, 1: one-cycle pulse per frame.
- i_next, input, 1: one-cycle request to advance one pattern.
- i_prev, input, 1: one-cycle request to step back one pattern.
- i_auto, input, 1: level; when high, auto-advances every FRAMES_PER_PATTERN frames.
- o_pattern, output, 4: registered pattern select driven to the generator.
- o_changed, output, 1: one-cycle pulse when o_pattern takes a new target value.
- o_busy, output, 1: high while a change is pending or blanking is in progress.

## Operation

**Reset values (asynchronous):**
- o_pattern = FIRST_PATTERN, o_changed = 0, o_busy = 0.
- State RUN; pending request cleared; auto counter = 0.

**Request latch (1 direction register plus valid bit):**
- i_next alone sets pending = NEXT. i_prev alone sets pending = PREV.
- i_next and i_prev in the same cycle is ignored. Any existing pending request is kept.
- A new request overwrites an older pending one (latest wins). At most one step is taken per frame.

**Step arithmetic:**
- NEXT: NUM_PATTERNS-1 wraps to FIRST_PATTERN; otherwise +1.
- PREV: FIRST_PATTERN wraps to NUM_PATTERNS-1; otherwise −1.

**Auto counter (width $clog2(FRAMES_PER_PATTERN)+1):**
- Held at 0 while i_auto is low or the state is not RUN.
- In RUN with i_auto high, increments on each i_frame_strobe.
- On the strobe where the counter equals FRAMES_PER_PATTERN-1, it generates an internal NEXT and clears to 0.
- A manual step committed at a strobe also clears the counter.
- A pending manual request takes priority over the auto step at the same strobe.

**States:**
- RUN: a valid pending request on i_frame_strobe commits the step.
- PENDING: o_busy = 1. This is the state in which a request is latched and waiting for a strobe.
- BLANK: only exists with the macro; see Configuration.

## Timing

- A request at cycle t commits at the first i_frame_strobe at cycle ≥ t. A request coincident with the strobe commits at that strobe.
- o_pattern and o_changed update on the clock edge after the committing strobe (1-cycle latency from strobe).
- o_changed is high for exactly one cycle per committed target value. It is never high for blank (pattern 0) insertion.
- o_busy rises the cycle after a request is latched. It falls together with the o_changed pulse.
- i_frame_strobe with no request and no auto step: no output change.
- When i_rst_n is asserted mid-PENDING or mid-BLANK, all outputs return to their reset values immediately and the pending request is discarded.

## Configuration

- Macro: PATTERN_SEQ_BLANK_EN.

**Defined:**
- The committing strobe loads o_pattern = 0 and the target register, and enters BLANK.
- BLANK counts BLANK_FRAMES strobes. On the last one, o_pattern = target and o_changed pulses; the state returns to RUN.
- Requests during BLANK are latched and served at the first strobe after BLANK exits.
- o_busy is high throughout BLANK.

**Undefined:**
- No BLANK state. The committing strobe loads the target directly. The BLANK_FRAMES parameter is unused.

## Test plan

- **Reset and first step:** reset, then one i_next pulse, then a strobe → o_pattern 1→2 one cycle after the strobe; o_changed pulses once.
- **Wrap-around:** with NUM_PATTERNS=10, drive o_pattern to 9, then i_next + strobe → 1. Then i_prev + strobe → 9.
- **Simultaneous and overwrite:** i_next and i_prev in the same cycle → no change at the strobe. i_prev then i_next before the strobe → exactly +1.
- **Auto mode:** FRAMES_PER_PATTERN=3, i_auto=1 → advances after every 3rd strobe. An i_next at frame 2 steps at that strobe and restarts the 3-frame count.
- **Blanking (macro defined), BLANK_FRAMES=2:** i_next + strobe → o_pattern = 0 for 2 frames, then target; o_busy high throughout; o_changed pulses only at target.
- **Reset mid-BLANK:** assert i_rst_n low during blanking → o_pattern = FIRST_PATTERN and o_busy = 0 asynchronously; no o_changed pulse.
